// File: rtl/seq_101_gen_pkg.sv
// Shared types and constants for the serial 101 pattern generator and its
// reference detector.
package seq_101_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // {older history bit, newer history bit, current bit}
  localparam logic [2:0] MATCH_101 = 3'b101;

endpackage

// File: rtl/seq_101_ref_mealy.sv
// Golden overlapping "101" Mealy detector; history advances only on valid bits
// and is cleared at the start of each transfer.
module seq_101_ref_mealy
  import seq_101_gen_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic bit_in,
  input  logic bit_vld,
  output logic z
);

  logic [1:0] r_hist;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_hist <= 2'b00;
    end else if (clr) begin
      r_hist <= 2'b00;
    end else if (bit_vld) begin
      r_hist <= {r_hist[0], bit_in};
    end
  end

  assign z = bit_vld && ({r_hist, bit_in} == MATCH_101);

endmodule

// File: rtl/seq_101_gen.sv
// Serializes a latched pattern MSB-first with programmable length, repetition
// count and idle gap, alongside the expected 101 detection for each valid bit.
module seq_101_gen
  import seq_101_gen_pkg::*;
#(
  parameter  int   WIDTH      = 8,
  parameter  logic IDLE_LEVEL = 1'b1,
  localparam int   LW         = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [LW-1:0]    len_in,
  input  logic [7:0]       rep_in,
  input  logic [3:0]       gap_in,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic             expect_z
);

  localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);
  localparam logic [LW-1:0] ONE     = LW'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pat,   w_pat_nxt;
  logic [LW-1:0]    r_len,   w_len_nxt;
  logic [LW-1:0]    r_idx,   w_idx_nxt;
  logic [7:0]       r_rem,   w_rem_nxt;
  logic [3:0]       r_gap,   w_gap_nxt;
  logic [3:0]       r_gcnt,  w_gcnt_nxt;
  logic             r_w, r_w_valid, r_busy, r_done;
  logic             w_accept;
  logic [LW-1:0]    w_len_eff;
  logic [WIDTH-1:0] w_pat_shift;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_len_eff = ((len_in == '0) || (len_in > LEN_MAX)) ? LEN_MAX : len_in;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_rem_nxt   = r_rem;
    w_gap_nxt   = r_gap;
    w_gcnt_nxt  = r_gcnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_pat_nxt   = pat_in;
          w_len_nxt   = w_len_eff;
          w_rem_nxt   = rep_in;
          w_gap_nxt   = gap_in;
          w_idx_nxt   = w_len_eff - ONE;
          w_state_nxt = (rep_in == 8'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (r_idx != '0) begin
          w_idx_nxt = r_idx - ONE;
        end else if (r_rem == 8'd1) begin
          w_rem_nxt   = 8'd0;
          w_state_nxt = DONE;
        end else begin
          // Index is reloaded here so GAP only has to count idle cycles.
          w_rem_nxt = r_rem - 8'd1;
          w_idx_nxt = r_len - ONE;
          if (r_gap != 4'd0) begin
            w_state_nxt = GAP;
            w_gcnt_nxt  = r_gap;
          end
        end
      end
      GAP: begin
        if (r_gcnt == 4'd1) begin
          w_state_nxt = SHIFT;
        end else begin
          w_gcnt_nxt = r_gcnt - 4'd1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state.
  assign w_pat_shift = w_pat_nxt >> w_idx_nxt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_pat     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_rem     <= 8'd0;
      r_gap     <= 4'd0;
      r_gcnt    <= 4'd0;
      r_w       <= IDLE_LEVEL;
      r_w_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pat     <= w_pat_nxt;
      r_len     <= w_len_nxt;
      r_idx     <= w_idx_nxt;
      r_rem     <= w_rem_nxt;
      r_gap     <= w_gap_nxt;
      r_gcnt    <= w_gcnt_nxt;
      r_w       <= (w_state_nxt == SHIFT) ? w_pat_shift[0] : IDLE_LEVEL;
      r_w_valid <= (w_state_nxt == SHIFT);
      r_busy    <= (w_state_nxt == SHIFT) || (w_state_nxt == GAP);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  assign w       = r_w;
  assign w_valid = r_w_valid;
  assign busy    = r_busy;
  assign done    = r_done;

  seq_101_ref_mealy u_ref (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (w_accept),
    .bit_in  (r_w),
    .bit_vld (r_w_valid),
    .z       (expect_z)
  );

endmodule
